nand_bus_sequencer: RTL and testbench

//  Byte-level NAND flash bus engine under the NFC page-copy controller; one instance per flash port (A, B).

---
 rtl/nand_bus_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_nand_bus_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_bus_sequencer.sv
// Byte-level NAND flash bus engine: turns single-byte requests into CLE/ALE/WEN/REN/IO waveforms.
// One instance sits on each flash port; the controller above only issues ops.
module nand_bus_sequencer #(
    parameter int          T_WP   = 2,
    parameter int          T_WH   = 1,
    parameter int          T_RP   = 2,
    parameter int          T_REH  = 1,
    parameter int          T_WB   = 5,
    parameter logic [19:0] TO_MAX = 20'hFFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rb_timeout,
    inout  wire  [7:0] F_IO,
    output logic       F_CLE,
    output logic       F_ALE,
    output logic       F_WEN,
    output logic       F_REN,
    input  logic       F_RB
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXP  = max2(max2(max2(T_WP, T_WH), max2(T_RP, T_REH)),
                                max2(T_WB, int'(TO_MAX)));
    localparam int CNT_W = $clog2(MAXP) + 1;

    localparam logic [CNT_W-1:0] WP_LAST  = CNT_W'(T_WP - 1);
    localparam logic [CNT_W-1:0] WH_LAST  = CNT_W'(T_WH - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] REH_LAST = CNT_W'(T_REH - 1);
    localparam logic [CNT_W-1:0] WB_LAST  = CNT_W'(T_WB - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(int'(TO_MAX) - 1);

    localparam logic [2:0] OP_CMD  = 3'd0;
    localparam logic [2:0] OP_ADDR = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_RD   = 3'd3;
    localparam logic [2:0] OP_WAIT = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        W_LOW,
        W_HIGH,
        R_LOW,
        R_HIGH,
        RB_DLY,
        RB_POLL
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cle_nxt;
    logic             ale_nxt;
    logic             wen_nxt;
    logic             ren_nxt;
    logic             io_oe;
    logic             oe_nxt;
    logic [7:0]       io_out;
    logic [7:0]       io_nxt;
    logic             rsp_valid_nxt;
    logic [7:0]       rsp_data_nxt;
    logic             timeout_nxt;
    logic             rb_meta;
    logic             rb_sync;

    assign F_IO      = io_oe ? io_out : 8'bzzzz_zzzz;
    assign req_ready = (state == IDLE);

    // F_RB is asynchronous to clk
    always_ff @(posedge clk) begin
        rb_meta <= F_RB;
        rb_sync <= rb_meta;
    end

    always_ff @(posedge clk) begin
        io_out <= io_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            F_CLE      <= 1'b0;
            F_ALE      <= 1'b0;
            F_WEN      <= 1'b1;
            F_REN      <= 1'b1;
            io_oe      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 8'h00;
            rb_timeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            F_CLE      <= cle_nxt;
            F_ALE      <= ale_nxt;
            F_WEN      <= wen_nxt;
            F_REN      <= ren_nxt;
            io_oe      <= oe_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_data   <= rsp_data_nxt;
            rb_timeout <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = (&cnt) ? cnt : cnt + 1'b1;
        cle_nxt       = F_CLE;
        ale_nxt       = F_ALE;
        wen_nxt       = F_WEN;
        ren_nxt       = F_REN;
        oe_nxt        = io_oe;
        io_nxt        = io_out;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = rsp_data;
        timeout_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    cnt_nxt = '0;
                    case (req_op)
                        OP_CMD, OP_ADDR, OP_WR: begin
                            wen_nxt   = 1'b0;
                            cle_nxt   = (req_op == OP_CMD);
                            ale_nxt   = (req_op == OP_ADDR);
                            oe_nxt    = 1'b1;
                            io_nxt    = req_data;
                            state_nxt = W_LOW;
                        end
                        OP_RD: begin
                            ren_nxt   = 1'b0;
                            oe_nxt    = 1'b0;
                            cle_nxt   = 1'b0;
                            ale_nxt   = 1'b0;
                            state_nxt = R_LOW;
                        end
                        OP_WAIT: begin
                            state_nxt = RB_DLY;
                        end
                        default: begin
                            // reserved op: one quiet cycle, reusing the tail of a write
                            cnt_nxt   = WH_LAST;
                            state_nxt = W_HIGH;
                        end
                    endcase
                end
            end
            W_LOW: begin
                if (cnt == WP_LAST) begin
                    wen_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = W_HIGH;
                end
            end
            W_HIGH: begin
                if (cnt == WH_LAST) begin
                    cle_nxt   = 1'b0;
                    ale_nxt   = 1'b0;
                    oe_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            R_LOW: begin
                if (cnt == RP_LAST) begin
                    ren_nxt       = 1'b1;
                    rsp_data_nxt  = F_IO;
                    rsp_valid_nxt = 1'b1;
                    cnt_nxt       = '0;
                    state_nxt     = R_HIGH;
                end
            end
            R_HIGH: begin
                if (cnt == REH_LAST) begin
                    state_nxt = IDLE;
                end
            end
            RB_DLY: begin
                if (cnt == WB_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = RB_POLL;
                end
            end
            RB_POLL: begin
                if (rb_sync) begin
                    state_nxt = IDLE;
                end else if (cnt == TO_LAST) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nand_bus_sequencer.sv
// Bench for nand_bus_sequencer: a timing model derived from per-op cycle counts checks every
// cycle, a small flash model answers the bus, and directed sequences pin literal expectations.
module tb_nand_bus_sequencer;

    localparam int T_WP   = 2;
    localparam int T_WH   = 1;
    localparam int T_RP   = 2;
    localparam int T_REH  = 1;
    localparam int T_WB   = 5;
    localparam int TO_TB  = 100;

    localparam logic [2:0] OP_CMD  = 3'd0;
    localparam logic [2:0] OP_ADDR = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_RD   = 3'd3;
    localparam logic [2:0] OP_WAIT = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rb_timeout;
    wire  [7:0] F_IO;
    logic       F_CLE;
    logic       F_ALE;
    logic       F_WEN;
    logic       F_REN;
    logic       F_RB;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nand_bus_sequencer #(
        .T_WP  (T_WP),
        .T_WH  (T_WH),
        .T_RP  (T_RP),
        .T_REH (T_REH),
        .T_WB  (T_WB),
        .TO_MAX(20'd100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rb_timeout(rb_timeout),
        .F_IO      (F_IO),
        .F_CLE     (F_CLE),
        .F_ALE     (F_ALE),
        .F_WEN     (F_WEN),
        .F_REN     (F_REN),
        .F_RB      (F_RB)
    );

    function automatic logic [7:0] pat_a(input int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    function automatic logic [7:0] pat_b(input int i);
        return 8'(i * 5 + 200);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- flash model ----------------
    logic [7:0] fl_mem [512];
    logic [7:0] fl_buf [512];
    logic [7:0] fl_cmd = 8'hFF;
    logic       fl_init = 1'b0;
    logic       wen_q = 1'b1;
    logic       ren_q = 1'b1;
    logic       rb_stuck = 1'b0;
    int         rptr = 0;
    int         wptr = 0;
    int         adr_cnt = 0;
    int         busy_cnt = 0;
    logic [7:0] adr_log [$];

    assign F_RB = rb_stuck ? 1'b0 : (busy_cnt == 0);
    assign F_IO = (!F_REN) ? fl_mem[rptr[8:0]] : 8'bzzzz_zzzz;

    always @(posedge clk) begin
        if (!fl_init) begin
            for (int i = 0; i < 512; i++) fl_mem[i] <= pat_a(i);
            fl_init <= 1'b1;
        end
        busy_cnt <= (busy_cnt > 0) ? busy_cnt - 1 : 0;
        if (!wen_q && F_WEN) begin
            if (F_CLE) begin
                fl_cmd <= F_IO;
                if (F_IO == 8'h00) begin
                    rptr    <= 0;
                    adr_cnt <= 0;
                end else if (F_IO == 8'h80) begin
                    wptr    <= 0;
                    adr_cnt <= 0;
                end else if (F_IO == 8'h10) begin
                    for (int i = 0; i < 512; i++) fl_mem[i] <= fl_buf[i];
                    busy_cnt <= 40;
                end
            end else if (F_ALE) begin
                adr_log.push_back(F_IO);
                adr_cnt <= adr_cnt + 1;
                if (fl_cmd == 8'h00 && adr_cnt == 2) busy_cnt <= 30;
            end else begin
                fl_buf[wptr[8:0]] <= F_IO;
                wptr <= wptr + 1;
            end
        end
        if (!ren_q && F_REN) rptr <= rptr + 1;
        wen_q <= F_WEN;
        ren_q <= F_REN;
    end

    // ---------------- cycle model + compare ----------------
    logic       m_en = 1'b0;
    logic       m_busy = 1'b0;
    logic [2:0] m_op = 3'd0;
    logic [7:0] m_data = 8'h00;
    int         m_k = 0;
    int         m_rd_idx = 0;
    logic [7:0] m_rdata = 8'h00;
    logic       m_to_next = 1'b0;
    logic       rb_h1 = 1'b1;
    logic       rb_h2 = 1'b1;
    int         n_rsp = 0;
    logic [7:0] first_rsp = 8'h00;

    initial begin : compare
        logic e_wen, e_ren, e_cle, e_ale, e_rv, e_io, done;
        forever begin
            @(negedge clk);
            if (m_en) begin
                e_wen = 1'b1; e_ren = 1'b1; e_cle = 1'b0; e_ale = 1'b0;
                e_rv = 1'b0; e_io = 1'b0;
                if (m_busy) begin
                    if (m_op == OP_CMD || m_op == OP_ADDR || m_op == OP_WR) begin
                        e_wen = (m_k > T_WP);
                        e_cle = (m_op == OP_CMD);
                        e_ale = (m_op == OP_ADDR);
                        e_io  = 1'b1;
                    end else if (m_op == OP_RD) begin
                        e_ren = (m_k > T_RP);
                        if (m_k == T_RP + 1) begin
                            e_rv    = 1'b1;
                            m_rdata = pat_a(m_rd_idx);
                            m_rd_idx++;
                        end
                    end
                end
                chk("req_ready", req_ready, !m_busy);
                chk("F_WEN", F_WEN, e_wen);
                chk("F_REN", F_REN, e_ren);
                chk("F_CLE", F_CLE, e_cle);
                chk("F_ALE", F_ALE, e_ale);
                chk("rsp_valid", rsp_valid, e_rv);
                chk("rsp_data", rsp_data, m_rdata);
                chk("rb_timeout", rb_timeout, m_to_next);
                chk("wen_ren_not_both_low", (!F_WEN && !F_REN), 1'b0);
                if (e_io) chk("F_IO_drive", F_IO, m_data);
                if (rsp_valid) begin
                    if (n_rsp == 0) first_rsp = rsp_data;
                    n_rsp++;
                end
            end
            m_to_next = 1'b0;
            if (rst) begin
                m_en = 1'b1; m_busy = 1'b0; m_rdata = 8'h00;
            end else if (!m_busy) begin
                if (req_valid) begin
                    m_busy = 1'b1; m_k = 1; m_op = req_op; m_data = req_data;
                    if (req_op == OP_CMD && req_data == 8'h00) m_rd_idx = 0;
                end
            end else begin
                done = 1'b0;
                case (m_op)
                    OP_CMD, OP_ADDR, OP_WR: done = (m_k == T_WP + T_WH);
                    OP_RD:   done = (m_k == T_RP + T_REH);
                    OP_WAIT: begin
                        if (m_k > T_WB) begin
                            if (rb_h2) done = 1'b1;
                            else if (m_k == T_WB + TO_TB) begin
                                done = 1'b1; m_to_next = 1'b1;
                            end
                        end
                    end
                    default: done = 1'b1;
                endcase
                if (done) m_busy = 1'b0;
                else m_k++;
            end
            rb_h2 = rb_h1;
            rb_h1 = F_RB;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [2:0] op, input logic [7:0] d);
        int n;
        n = 0;
        req_valid = 1'b1; req_op = op; req_data = d;
        @(negedge clk);
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("issue_wait_bound", n, 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!req_ready && n < 1000) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 1000) chk("idle_wait_bound", n, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [3:0] w_wen, w_rdy, w_cle;
        int n;
        rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_wen", F_WEN, 1'b1);
        chk("rst_ren", F_REN, 1'b1);
        chk("rst_cle_ale", {F_CLE, F_ALE}, 2'b00);
        chk("rst_rsp_data", rsp_data, 8'h00);

        // CMD 00: WEN low 2 cycles, high 1, then ready
        issue(OP_CMD, 8'h00);
        w_wen = 4'b1100; w_rdy = 4'b1000; w_cle = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            chk("cmd_wen_seq", F_WEN, w_wen[i]);
            chk("cmd_ready_seq", req_ready, w_rdy[i]);
            chk("cmd_cle_seq", F_CLE, w_cle[i]);
            if (i < 3) chk("cmd_io", F_IO, 8'h00);
            @(posedge clk);
            #1;
        end

        // back-to-back ADDR
        adr_log.delete();
        issue(OP_ADDR, 8'h00);
        issue(OP_ADDR, 8'h00);
        issue(OP_ADDR, 8'h01);
        wait_idle();
        @(posedge clk);
        #1;
        chk("addr_count", adr_log.size(), 3);
        if (adr_log.size() == 3) begin
            chk("addr0", adr_log[0], 8'h00);
            chk("addr1", adr_log[1], 8'h00);
            chk("addr2", adr_log[2], 8'h01);
        end

        // reset mid-W_LOW for 3 cycles
        issue(OP_CMD, 8'hA5);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_wen", F_WEN, 1'b1);
        chk("midrst_cle_ale", {F_CLE, F_ALE}, 2'b00);
        chk("midrst_ready", req_ready, 1'b1);

        // reserved op: one busy cycle
        issue(3'd6, 8'h5A);
        chk("rsvd_busy", req_ready, 1'b0);
        chk("rsvd_quiet", {F_WEN, F_REN, F_CLE, F_ALE}, 4'b1100);
        @(posedge clk);
        #1;
        chk("rsvd_back", req_ready, 1'b1);

        // page read
        issue(OP_CMD, 8'h00);
        issue(OP_ADDR, 8'h00);
        issue(OP_ADDR, 8'h00);
        issue(OP_ADDR, 8'h00);
        issue(OP_WAIT, 8'h00);
        n_rsp = 0;
        for (int i = 0; i < 512; i++) issue(OP_RD, 8'h00);
        wait_idle();
        @(posedge clk);
        #1;
        chk("rd_count", n_rsp, 512);
        chk("rd_first", first_rsp, 8'h0B);
        chk("rd_last", rsp_data, 8'hD9);

        // WAIT_RB timeout with F_RB stuck low
        rb_stuck = 1'b1;
        issue(OP_WAIT, 8'h00);
        n = 0;
        while (!rb_timeout && n < 300) begin
            @(posedge clk);
            #1 n++;
        end
        chk("timeout_latency", n, 105);
        rb_stuck = 1'b0;
        wait_idle();

        // page program
        issue(OP_CMD, 8'h80);
        issue(OP_ADDR, 8'h00);
        issue(OP_ADDR, 8'h00);
        issue(OP_ADDR, 8'h02);
        for (int i = 0; i < 512; i++) issue(OP_WR, pat_b(i));
        issue(OP_CMD, 8'h10);
        issue(OP_WAIT, 8'h00);
        wait_idle();
        @(posedge clk);
        #1;
        chk("prog_first", fl_mem[0], 8'hC8);
        chk("prog_last", fl_mem[511], 8'hC3);
        for (int i = 0; i < 512; i++) chk("prog_byte", fl_mem[i], pat_b(i));

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
